// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble receive path: widths, assembler state
// encoding and the byte reassembly rule.
package nibble_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [BYTE_W-1:0] byte_t;

    // Assembler states, kept as plain constants for legacy tool flows.
    localparam logic [0:0] ST_IDLE = 1'b0;  // expecting the first nibble of a byte
    localparam logic [0:0] ST_HALF = 1'b1;  // first nibble held, expecting the second

    // Rebuild a byte from its two nibbles. The transmitter swapped the nibble
    // order when swap was set, so the second nibble is then the high half.
    function automatic byte_t assemble_byte(input nib_t first_nib, input nib_t second_nib,
                                            input logic swap);
        return swap ? {second_nib, first_nib} : {first_nib, second_nib};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with registered occupancy. The head byte is presented
// combinationally from storage and forced to zero while the FIFO is empty.
module byte_fifo
    import nibble_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  byte_t                  wr_data_i,
    input  logic                   rd_en_i,
    output byte_t                  rd_data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    byte_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_wr   = wr_en_i & ~full_o;
    assign do_rd   = rd_en_i & ~empty_o;

    // Gating with empty makes the output read zero after reset without
    // having to clear the storage array.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage write; data only matters once the matching level bump exposes it.
    // NOTE: the array has no reset -- stale contents are unreachable while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/nibble_assembler.sv
// Reassembles bytes from a framed nibble stream, undoes the per-byte
// transmit-side nibble swap, flags framing errors and buffers bytes.
module nibble_assembler
    import nibble_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NIB_W-1:0]       nib_in,
    input  logic                   nib_valid,
    input  logic                   nib_first,
    input  logic                   swap_en,
    output logic                   nib_ready,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] level
);

    logic [0:0] state_q, state_d;
    nib_t       hi_q, hi_d;
    logic       swap_q, swap_d;
    logic       err_q, err_d;
    logic       err_set;
    logic       fifo_wr;
    logic       fifo_rd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;

    // Ready depends only on registered occupancy, never on out_ready.
    assign nib_ready = ~fifo_full;
    assign accept    = nib_valid & nib_ready;
    assign out_valid = ~fifo_empty;
    assign fifo_rd   = out_valid & out_ready;
    assign err       = err_q;

    // Next-state logic for the assembler and the sticky error flag.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        swap_d  = swap_q;
        err_set = 1'b0;
        fifo_wr = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (nib_first) begin
                        hi_d    = nib_in;
                        swap_d  = swap_en;
                        state_d = ST_HALF;
                    end else begin
                        err_set = 1'b1;      // orphan second nibble is dropped
                    end
                end
                ST_HALF: begin
                    if (nib_first) begin
                        hi_d    = nib_in;    // restart the byte with the new nibble
                        swap_d  = swap_en;
                        err_set = 1'b1;
                    end else begin
                        fifo_wr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A new error wins over a simultaneous clear.
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // Assembler and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (assemble_byte(hi_q, nib_in, swap_q)),
        .rd_en_i   (fifo_rd),
        .rd_data_o (out_data),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule
